// File: rtl/gesture_pkg.sv
// Shared types and defaults for the gesture frame sequencer.
package gesture_pkg;
  localparam int H_ACT_DEF = 600;
  localparam int V_ACT_DEF = 500;
  localparam int DIV_W_DEF = 20;

  // res_flags bit positions: {geom_err, div0, empty}
  localparam int FLAG_EMPTY = 0;
  localparam int FLAG_DIV0  = 1;
  localparam int FLAG_GEOM  = 2;

  typedef enum logic [2:0] {IDLE, FRAME, CAPTURE, MUL, DIV, HOLD} state_e;
endpackage

// File: rtl/gesture_seq_div.sv
// Restoring divider, one quotient bit per cycle, fixed DIV_W-cycle latency.
// The quotient register is the result; it holds until the next start.
// A zero divisor naturally yields an all-ones quotient. DIV_W >= 2.
module gesture_seq_div import gesture_pkg::*; #(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic             div0,
  output logic             last
);
  localparam int CW = $clog2(DIV_W);

  logic [DIV_W-1:0] rem, quo, dvs;
  logic [CW-1:0]    cnt;
  logic             running;
  logic [DIV_W:0]   shifted, diff;
  logic             take;

  // Remainder stays below a nonzero divisor, so the sign of the trial
  // subtraction decides each quotient bit.
  assign shifted = {rem, quo[DIV_W-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign take    = ~diff[DIV_W] | ~|dvs;
  assign last    = running && (cnt == CW'(DIV_W - 1));
  assign quotient = quo;

  // Load operands on start, then shift/subtract one bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      div0    <= 1'b0;
    end else if (start) begin
      rem     <= '0;
      quo     <= dividend;
      dvs     <= divisor;
      cnt     <= '0;
      running <= 1'b1;
      div0    <= ~|divisor;
    end else if (running) begin
      rem <= take ? diff[DIV_W-1:0] : shifted[DIV_W-1:0];
      quo <= {quo[DIV_W-2:0], take};
      cnt <= cnt + CW'(1);
      if (last) running <= 1'b0;
    end
  end
endmodule

// File: rtl/gesture_frame_ctrl.sv
// Frame sequencer: detector clear, geometry check, box area and
// fingertip ratio, one valid/ready result per processed frame.
module gesture_frame_ctrl import gesture_pkg::*; #(
  parameter int H_ACT = H_ACT_DEF,
  parameter int V_ACT = V_ACT_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             per_frame_vsync,
  input  logic             per_frame_hsync,
  input  logic             per_frame_clken,
  output logic             det_clear,
  input  logic [11:0]      box_x_min,
  input  logic [11:0]      box_x_max,
  input  logic [11:0]      box_y_min,
  input  logic [11:0]      box_y_max,
  input  logic [DIV_W-1:0] box_length,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DIV_W-1:0] res_area,
  output logic [DIV_W-1:0] res_ratio,
  output logic [2:0]       res_flags,
  output logic             busy,
  output logic [7:0]       overrun_cnt
);
  state_e           state;
  logic             vsync_q, hsync_q, rise, fall, line_inc;
  logic [15:0]      pix_cnt, line_cnt, line_nxt;
  logic             geom_err, empty_q;
  logic [11:0]      x_min_q, x_max_q, y_min_q, y_max_q;
  logic [DIV_W-1:0] len_q, area_nxt;
  logic [11:0]      dx, dy;
  logic [23:0]      prod;
  logic [DIV_W+23:0] prod_w;
  logic             div_last, div0;

  assign rise     = per_frame_vsync & ~vsync_q;
  assign fall     = ~per_frame_vsync & vsync_q;
  assign line_inc = ~per_frame_hsync & hsync_q & (pix_cnt != 16'd0);
  assign line_nxt = line_cnt + {15'd0, line_inc};
  assign busy     = (state != IDLE);

  // Differences wrap for an empty box; the result is forced to zero then.
  assign dx     = x_max_q - x_min_q;
  assign dy     = y_max_q - y_min_q;
  assign prod   = 24'(dx) * 24'(dy);
  assign prod_w = {{DIV_W{1'b0}}, prod};
  assign area_nxt = empty_q                       ? '0 :
                    (|prod_w[DIV_W+23:DIV_W])     ? '1 :
                                                    prod_w[DIV_W-1:0];

  gesture_seq_div #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (state == MUL),
    .dividend (area_nxt),
    .divisor  (len_q),
    .quotient (res_ratio),
    .div0     (div0),
    .last     (div_last)
  );

  // Sync edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
    end else begin
      vsync_q <= per_frame_vsync;
      hsync_q <= per_frame_hsync;
    end
  end

  // Frame FSM with geometry counters and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      det_clear   <= 1'b0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      geom_err    <= 1'b0;
      empty_q     <= 1'b0;
      x_min_q     <= '0;
      x_max_q     <= '0;
      y_min_q     <= '0;
      y_max_q     <= '0;
      len_q       <= '0;
      res_valid   <= 1'b0;
      res_area    <= '0;
      res_flags   <= '0;
      overrun_cnt <= '0;
    end else begin
      det_clear <= 1'b0;
      // A frame start while busy is dropped and counted.
      if (rise && state != IDLE && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;
      case (state)
        IDLE: if (rise) begin
          det_clear <= 1'b1;
          pix_cnt   <= '0;
          line_cnt  <= '0;
          geom_err  <= 1'b0;
          state     <= FRAME;
        end
        FRAME: begin
          if (line_inc) begin
            line_cnt <= line_nxt;
            pix_cnt  <= '0;
            if (pix_cnt != 16'(H_ACT)) geom_err <= 1'b1;
          end else if (per_frame_clken) begin
            pix_cnt <= pix_cnt + 16'd1;
          end
          // line_nxt covers a line that ends on the same edge as the frame.
          if (fall) begin
            if (line_nxt != 16'(V_ACT)) geom_err <= 1'b1;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          x_min_q <= box_x_min;
          x_max_q <= box_x_max;
          y_min_q <= box_y_min;
          y_max_q <= box_y_max;
          len_q   <= box_length;
          empty_q <= (box_x_max < box_x_min) | (box_y_max < box_y_min);
          state   <= MUL;
        end
        MUL: begin
          res_area <= area_nxt;
          state    <= DIV;
        end
        DIV: if (div_last) begin
          res_flags[FLAG_GEOM]  <= geom_err;
          res_flags[FLAG_DIV0]  <= div0;
          res_flags[FLAG_EMPTY] <= empty_q;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gesture_frame_ctrl.sv
// Directed bench for gesture_frame_ctrl with a transaction-level model.
module tb_gesture_frame_ctrl;
  localparam int H   = 20;
  localparam int V   = 6;
  localparam int LAT = 22;

  logic        clk, rst_n;
  logic        vsync, hsync, clken, res_ready;
  logic        det_clear, res_valid, busy;
  logic [11:0] bx_min, bx_max, by_min, by_max;
  logic [19:0] b_len, res_area, res_ratio;
  logic [2:0]  res_flags;
  logic [7:0]  overrun_cnt;
  logic        exp_geom;

  int checks = 0, errors = 0, dc_seen = 0;

  gesture_frame_ctrl #(.H_ACT(H), .V_ACT(V), .DIV_W(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vsync), .per_frame_hsync(hsync), .per_frame_clken(clken),
    .det_clear(det_clear),
    .box_x_min(bx_min), .box_x_max(bx_max), .box_y_min(by_min), .box_y_max(by_max),
    .box_length(b_len),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_area(res_area), .res_ratio(res_ratio), .res_flags(res_flags),
    .busy(busy), .overrun_cnt(overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic        m_prev = 0, m_busy = 0, m_inframe = 0, m_pend = 0, m_valid = 0, m_dc = 0;
  int          m_cnt = 0, m_ovr = 0;
  logic [31:0] m_area = 0, m_ratio = 0, m_flags = 0, n_area, n_ratio, n_flags;

  function automatic void expect_result(output logic [31:0] a, output logic [31:0] r,
                                        output logic [31:0] f);
    logic emp;
    longint p;
    emp = (bx_max < bx_min) || (by_max < by_min);
    p   = longint'(bx_max - bx_min) * longint'(by_max - by_min);
    a   = emp ? 0 : (p > 64'd1048575 ? 32'hFFFFF : 32'(p));
    r   = (b_len == 0) ? 32'hFFFFF : a / 32'(b_len);
    f   = {29'd0, exp_geom, (b_len == 0), emp};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev = 0; m_busy = 0; m_inframe = 0; m_pend = 0; m_valid = 0;
      m_dc = 0; m_cnt = 0; m_ovr = 0;
    end else begin
      logic rs, fl;
      rs = vsync && !m_prev;
      fl = !vsync && m_prev;
      m_prev = vsync;
      m_dc = 0;
      if (rs) begin
        if (!m_busy) begin m_dc = 1; m_busy = 1; m_inframe = 1; end
        else if (m_ovr < 255) m_ovr++;
      end
      if (m_valid && res_ready) begin m_valid = 0; m_busy = 0; end
      if (m_pend) begin
        m_cnt++;
        if (m_cnt == LAT) begin
          m_pend = 0; m_valid = 1;
          m_area = n_area; m_ratio = n_ratio; m_flags = n_flags;
        end
      end
      if (fl && m_inframe) begin
        m_inframe = 0; m_pend = 1; m_cnt = 0;
        expect_result(n_area, n_ratio, n_flags);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (det_clear) dc_seen++;
    chk("det_clear", 32'(det_clear), 32'(m_dc));
    chk("res_valid", 32'(res_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
    if (m_valid) begin
      chk("res_area", 32'(res_area), m_area);
      chk("res_ratio", 32'(res_ratio), m_ratio);
      chk("res_flags", 32'(res_flags), m_flags);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic frame(input int nlines, input int short_ln,
                       input logic [11:0] xa, input logic [11:0] xb,
                       input logic [11:0] ya, input logic [11:0] yb,
                       input logic [19:0] len);
    bx_min = xa; bx_max = xb; by_min = ya; by_max = yb; b_len = len;
    exp_geom = (nlines != V) || (short_ln >= 0);
    tick; vsync = 1;
    tick; tick;
    for (int l = 0; l < nlines; l++) begin
      tick; hsync = 1; clken = 1;
      repeat ((l == short_ln) ? H - 1 : H) tick;
      hsync = 0; clken = 0;
      tick; tick;
    end
    tick; vsync = 0;
  endtask

  task automatic vpulse;
    tick; vsync = 1;
    repeat (3) tick;
    vsync = 0;
    repeat (3) tick;
  endtask

  // Cycles from the frame-end edge to res_valid; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      tick;
      if (res_valid) begin lat = i - 1; break; end
    end
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 100) begin tick; n++; end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat, dc0;
    rst_n = 0; vsync = 0; hsync = 0; clken = 0; res_ready = 1;
    bx_min = 0; bx_max = 0; by_min = 0; by_max = 0; b_len = 0; exp_geom = 0;
    repeat (3) tick;
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_area", 32'(res_area), 0);
    chk("rst_ratio", 32'(res_ratio), 0);
    chk("rst_flags", 32'(res_flags), 0);
    rst_n = 1;
    tick;

    // Nominal frame.
    dc0 = dc_seen;
    frame(V, -1, 100, 300, 50, 250, 400);
    wait_valid(lat);
    chk("nom_latency", 32'(lat), LAT);
    chk("nom_area", 32'(res_area), 40000);
    chk("nom_ratio", 32'(res_ratio), 100);
    chk("nom_flags", 32'(res_flags), 3'b000);
    chk("nom_det_clear_count", 32'(dc_seen - dc0), 1);
    wait_idle;

    // Divide by zero.
    frame(V, -1, 0, 10, 0, 10, 0);
    wait_valid(lat);
    chk("div0_area", 32'(res_area), 100);
    chk("div0_ratio", 32'(res_ratio), 20'hFFFFF);
    chk("div0_flags", 32'(res_flags), 3'b010);
    wait_idle;

    // Empty box.
    frame(V, -1, 600, 5, 0, 10, 7);
    wait_valid(lat);
    chk("empty_area", 32'(res_area), 0);
    chk("empty_ratio", 32'(res_ratio), 0);
    chk("empty_flags", 32'(res_flags), 3'b001);
    wait_idle;

    // Short line, then a correct frame.
    frame(V, 2, 10, 20, 10, 20, 3);
    wait_valid(lat);
    chk("geom_flags", 32'(res_flags), 3'b100);
    wait_idle;
    frame(V, -1, 10, 20, 10, 20, 3);
    wait_valid(lat);
    chk("geom_recover_flags", 32'(res_flags), 3'b000);
    chk("geom_recover_ratio", 32'(res_ratio), 33);
    wait_idle;

    // Wrong line count and saturated area.
    frame(V - 1, -1, 0, 4095, 0, 4095, 1);
    wait_valid(lat);
    chk("sat_area", 32'(res_area), 20'hFFFFF);
    chk("lines_flags", 32'(res_flags), 3'b100);
    wait_idle;

    // Stalled consumer: two skipped frames.
    res_ready = 0;
    frame(V, -1, 1, 9, 1, 5, 4);
    wait_valid(lat);
    dc0 = dc_seen;
    vpulse; vpulse;
    chk("ovr_count", 32'(overrun_cnt), 2);
    chk("ovr_no_clear", 32'(dc_seen - dc0), 0);
    chk("ovr_hold_area", 32'(res_area), 32);
    res_ready = 1;
    wait_idle;
    frame(V, -1, 2, 12, 3, 13, 25);
    wait_valid(lat);
    chk("post_ovr_ratio", 32'(res_ratio), 4);
    wait_idle;

    // Reset in the middle of the divide.
    frame(V, -1, 0, 10, 0, 10, 3);
    repeat (10) tick;
    rst_n = 0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_area", 32'(res_area), 0);
    chk("mid_rst_ratio", 32'(res_ratio), 0);
    chk("mid_rst_ovr", 32'(overrun_cnt), 0);
    repeat (2) tick;
    rst_n = 1;
    tick;
    frame(V, -1, 0, 10, 0, 10, 3);
    wait_valid(lat);
    chk("post_rst_latency", 32'(lat), LAT);
    chk("post_rst_ratio", 32'(res_ratio), 33);
    wait_idle;

    repeat (3) tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
